// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command assembler.
//   state_t           : assembler FSM states (IDLE_HI, WAIT_LO)
//   BAUD_CLKS_PER_BIT : system clocks per UART bit
//   DEF_TIMEOUT_CLKS  : default inter-byte timeout, two 10-bit byte times
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

  typedef enum logic {
    IDLE_HI = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  localparam int BAUD_CLKS_PER_BIT = 2604;
  localparam int DEF_TIMEOUT_CLKS  = 2 * 10 * BAUD_CLKS_PER_BIT;

endpackage

// File: rtl/uart_cmd_assembler.sv
// ---------------------------------------------------------------------------
// uart_cmd_assembler
// Pairs two bytes from the UART receiver (high byte first) into a 16-bit
// command for the command processor. A high byte left waiting longer than
// TIMEOUT_CLKS is dropped so a lost byte cannot misalign the stream.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   rx_data[7:0] in   byte from the UART receiver
//   rdy          in   receiver byte-valid level, held until cleared
//   clr_rdy      out  combinational clear back to the receiver
//   cmd[15:0]    out  assembled command {high byte, low byte}
//   cmd_rdy      out  command valid (set/reset flop)
//   clr_cmd_rdy  in   consumer acknowledge, clears cmd_rdy
//   sync_err     out  one-cycle pulse when a high byte is dropped on timeout
//   overrun      out  sticky overwrite flag (only with UART_CMD_OVERRUN_EN)
//
// Build option: define UART_CMD_OVERRUN_EN to add the overrun output.
// ---------------------------------------------------------------------------
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rdy,
  output logic        clr_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        sync_err
`ifdef UART_CMD_OVERRUN_EN
  ,
  output logic        overrun
`endif
);

  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CLKS - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_tmo_cnt;
  logic [7:0]         r_hi_byte;
  logic [15:0]        r_cmd;
  logic               r_cmd_rdy;
  logic               r_sync_err;
  logic               w_state_ok;
  logic               w_lo_accept;

  // Both states consume a byte, so the receiver is always cleared on the
  // cycle it presents one; reset suppresses the clear.
  assign w_state_ok  = (r_state == IDLE_HI) || (r_state == WAIT_LO);
  assign clr_rdy     = rdy & rst_n & w_state_ok;
  assign w_lo_accept = (r_state == WAIT_LO) && rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE_HI;
      r_tmo_cnt  <= '0;
      r_hi_byte  <= 8'h00;
      r_cmd      <= 16'h0000;
      r_cmd_rdy  <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= 1'b0;
      // Consumer clear is the default; a completing low byte below overrides it.
      if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;
      case (r_state)
        IDLE_HI: begin
          if (rdy) begin
            r_hi_byte <= rx_data;
            r_tmo_cnt <= TMO_LOAD;
            r_cmd_rdy <= 1'b0;
            r_state   <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          // A byte on the terminal-count cycle still counts as the low byte.
          if (rdy) begin
            r_cmd     <= {r_hi_byte, rx_data};
            r_cmd_rdy <= 1'b1;
            r_state   <= IDLE_HI;
          end else if (r_tmo_cnt != '0) begin
            r_tmo_cnt <= r_tmo_cnt - CNT_W'(1);
          end else begin
            r_state    <= IDLE_HI;
            r_sync_err <= 1'b1;
          end
        end
        default: r_state <= IDLE_HI;
      endcase
    end
  end

  assign cmd      = r_cmd;
  assign cmd_rdy  = r_cmd_rdy;
  assign sync_err = r_sync_err;

`ifdef UART_CMD_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_lo_accept && r_cmd_rdy && !clr_cmd_rdy) begin
      r_overrun <= 1'b1;
    end else if (clr_cmd_rdy) begin
      r_overrun <= 1'b0;
    end
  end

  assign overrun = r_overrun;
`else
  logic w_unused;
  assign w_unused = w_lo_accept;
`endif

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_assembler
// Directed and randomized bench for uart_cmd_assembler with a short timeout.
// Expected outputs come from a byte-pairing model that tracks how long a high
// byte has been waiting.
// ---------------------------------------------------------------------------
module tb_uart_cmd_assembler;

  localparam int T_CLKS = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rdy = 1'b0;
  logic        clr_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        sync_err;
`ifdef UART_CMD_OVERRUN_EN
  logic        overrun;
`endif

  uart_cmd_assembler #(
    .TIMEOUT_CLKS(T_CLKS),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rdy        (rdy),
    .clr_rdy    (clr_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .sync_err   (sync_err)
`ifdef UART_CMD_OVERRUN_EN
    ,
    .overrun    (overrun)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_clr = 0;

  // reference model: is a high byte pending, and for how many cycles
  logic        m_hold = 1'b0;
  logic [7:0]  m_hi   = 8'h00;
  int          m_age  = 0;
  logic [15:0] m_cmd  = 16'h0000;
  logic        m_rdy  = 1'b0;
  logic        m_err  = 1'b0;
  logic        m_ovr  = 1'b0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [7:0] d, input logic clr,
                            input logic rs);
    logic set_ovr;
    if (!rs) begin
      m_hold = 1'b0; m_hi = 8'h00; m_age = 0;
      m_cmd = 16'h0000; m_rdy = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
      return;
    end
    m_err   = 1'b0;
    set_ovr = m_hold && r && m_rdy && !clr;
    if (set_ovr) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    if (!m_hold) begin
      if (clr) m_rdy = 1'b0;
      if (r) begin
        m_hold = 1'b1; m_hi = d; m_age = 0; m_rdy = 1'b0;
      end
    end else begin
      m_age++;
      if (r) begin
        m_cmd  = {m_hi, d};
        m_rdy  = 1'b1;
        m_hold = 1'b0;
      end else begin
        if (clr) m_rdy = 1'b0;
        if (m_age == T_CLKS) begin
          m_hold = 1'b0;
          m_err  = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive inputs just after a falling edge, check the clear,
  // advance the model across the rising edge, check outputs at next falling edge.
  task automatic cyc(input logic r, input logic [7:0] d, input logic clr, input logic rs);
    rdy = r; rx_data = d; clr_cmd_rdy = clr; rst_n = rs;
    #1;
    chk("clr_rdy", {15'b0, clr_rdy}, {15'b0, r & rs});
    if (clr_rdy === 1'b1) n_clr++;
    model_step(r, d, clr, rs);
    @(negedge clk);
    chk("cmd", cmd, m_cmd);
    chk("cmd_rdy", {15'b0, cmd_rdy}, {15'b0, m_rdy});
    chk("sync_err", {15'b0, sync_err}, {15'b0, m_err});
`ifdef UART_CMD_OVERRUN_EN
    chk("overrun", {15'b0, overrun}, {15'b0, m_ovr});
`endif
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    // reset
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_cmd_rdy", {15'b0, cmd_rdy}, 16'h0000);

    // basic pair
    n_clr = 0;
    cyc(1'b1, 8'hA5, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h3C, 1'b0, 1'b1);
    chk("pair_cmd", cmd, 16'hA53C);
    chk("pair_rdy", {15'b0, cmd_rdy}, 16'h0001);
    chk("clr_rdy_count", 16'(n_clr), 16'd2);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("ack_clears", {15'b0, cmd_rdy}, 16'h0000);

    // stranded high byte times out after exactly T_CLKS waiting cycles
    cyc(1'b1, 8'h12, 1'b0, 1'b1);
    idle(T_CLKS - 1);
    chk("tmo_not_yet", {15'b0, sync_err}, 16'h0000);
    idle(1);
    chk("tmo_pulse", {15'b0, sync_err}, 16'h0001);
    idle(1);
    chk("tmo_one_cycle", {15'b0, sync_err}, 16'h0000);
    cyc(1'b1, 8'h34, 1'b0, 1'b1);
    cyc(1'b1, 8'h56, 1'b0, 1'b1);
    chk("after_tmo_cmd", cmd, 16'h3456);

    // low byte on the terminal-count cycle is still accepted
    cyc(1'b1, 8'h9A, 1'b0, 1'b1);
    idle(T_CLKS - 1);
    cyc(1'b1, 8'hBC, 1'b0, 1'b1);
    chk("edge_cmd", cmd, 16'h9ABC);
    chk("edge_no_err", {15'b0, sync_err}, 16'h0000);
    idle(1);
    chk("edge_no_err_late", {15'b0, sync_err}, 16'h0000);

    // completion and acknowledge on the same cycle: set wins
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    cyc(1'b1, 8'h88, 1'b1, 1'b1);
    chk("set_wins_rdy", {15'b0, cmd_rdy}, 16'h0001);
    chk("set_wins_cmd", cmd, 16'h7788);

    // back-to-back commands without acknowledge
    cyc(1'b1, 8'h11, 1'b0, 1'b1);
    cyc(1'b1, 8'h11, 1'b0, 1'b1);
    cyc(1'b1, 8'h22, 1'b0, 1'b1);
    cyc(1'b1, 8'h22, 1'b0, 1'b1);
    chk("overwrite_cmd", cmd, 16'h2222);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);

    // reset while waiting for a low byte, rdy high during reset
    cyc(1'b1, 8'hFF, 1'b0, 1'b1);
    idle(3);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("midrst_cmd", cmd, 16'h0000);
    chk("midrst_rdy", {15'b0, cmd_rdy}, 16'h0000);
    cyc(1'b1, 8'h01, 1'b0, 1'b1);
    cyc(1'b1, 8'h02, 1'b0, 1'b1);
    chk("midrst_pair", cmd, 16'h0102);

    // randomized byte stream with gaps around the timeout
    for (int i = 0; i < 120; i++) begin
      int gap;
      case ($urandom_range(0, 3))
        0:       gap = $urandom_range(0, 3);
        1:       gap = $urandom_range(T_CLKS - 2, T_CLKS + 1);
        2:       gap = $urandom_range(4, 20);
        default: gap = 0;
      endcase
      for (int g = 0; g < gap; g++)
        cyc(1'b0, 8'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
      cyc(1'b1, 8'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 40) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
